// File: rtl/ssc_arb_pkg.sv
// Shared types and constants for the seven-segment display share arbiter.
package ssc_arb_pkg;

   localparam int HOLD_W = 32;
   localparam int DISP_W = 24;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [7:0] channel;
      logic [7:0] lt;
      logic [7:0] ut;
   } disp_word_t;

endpackage

// File: rtl/ssc_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or above ptr_in,
// wrapping modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [IDX_W-1:0]   ptr_in,
   output logic               valid_out,
   output logic [IDX_W-1:0]   idx_out
);

   localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl_s;
   logic [NUM_REQ-1:0]   rot_s;
   logic [IDX_W-1:0]     off_s;
   logic [IDX_W:0]       sum_s;

   // Rotate so that the pointer position lands on bit 0.
   assign dbl_s = {req_in, req_in} >> ptr_in;
   assign rot_s = dbl_s[NUM_REQ-1:0];

   // Lowest set bit of the rotated vector is the winning offset.
   always_comb begin
      off_s = {IDX_W{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         off_s = rot_s[i] ? IDX_W'(i) : off_s;
      end
   end

   assign sum_s     = {1'b0, ptr_in} + {1'b0, off_s};
   assign idx_out   = (sum_s >= NUM_EXT) ? IDX_W'(sum_s - NUM_EXT) : sum_s[IDX_W-1:0];
   assign valid_out = |req_in;

endmodule

// File: rtl/ssc_share_arbiter.sv
// Round-robin sharing of one seven-segment controller with a minimum hold time.
// Optional urgent requester 0 when SSC_ARB_PRIORITY0_EN is defined.
module ssc_share_arbiter
   import ssc_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic [NUM_REQ-1:0]          req_in,
   input  logic [DISP_W*NUM_REQ-1:0]   val_in,
   output logic [NUM_REQ-1:0]          gnt_out,
   output logic [$clog2(NUM_REQ)-1:0]  owner_out,
   output logic                        active_out,
   output logic [7:0]                  channel_sel_out,
   output logic [7:0]                  lt_out,
   output logic [7:0]                  ut_out
);

   localparam int                 IDX_W     = $clog2(NUM_REQ);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

   arb_state_t         state_q,    state_d;
   logic [NUM_REQ-1:0] gnt_q,      gnt_d;
   logic [IDX_W-1:0]   owner_q,    owner_d;
   logic               active_q,   active_d;
   disp_word_t         disp_q,     disp_d;
   logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

   disp_word_t         words_s [NUM_REQ];
   logic [IDX_W-1:0]   owner_inc_s;
   logic               own_req_s;
   logic               others_s;
   logic               expired_s;
   logic               release_s;
   logic [IDX_W-1:0]   release_ptr_s;
   logic [IDX_W-1:0]   pick_ptr_s;
   logic               rr_vld_s;
   logic [IDX_W-1:0]   rr_idx_s;
   logic               pick_vld_s;
   logic [IDX_W-1:0]   pick_idx_s;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words_s[g] = disp_word_t'(val_in[DISP_W*g +: DISP_W]);
   end

   assign owner_inc_s = (owner_q == LAST_IDX) ? {IDX_W{1'b0}} : owner_q + IDX_W'(1);
   assign own_req_s   = |(req_in & gnt_q);
   assign others_s    = |(req_in & ~gnt_q);
   assign expired_s   = (hold_cnt_q == HOLD_LAST);

`ifdef SSC_ARB_PRIORITY0_EN
   logic             preempt_s;
   logic             prio_pick_s;
   logic             resume_vld_q, resume_vld_d;
   logic [IDX_W-1:0] resume_ptr_q, resume_ptr_d;

   // Requester 0 cuts in on any other owner; rotation later resumes at the victim.
   assign preempt_s     = (state_q == OWN) && req_in[0] && (owner_q != {IDX_W{1'b0}});
   assign prio_pick_s   = req_in[0] && !((state_q == OWN) && (owner_q == {IDX_W{1'b0}}));
   assign pick_ptr_s    = (state_q == IDLE) ? rr_ptr_q :
                          (resume_vld_q ? resume_ptr_q : owner_inc_s);
   assign pick_vld_s    = rr_vld_s;
   assign pick_idx_s    = prio_pick_s ? {IDX_W{1'b0}} : rr_idx_s;
   assign release_s     = preempt_s || (expired_s && (!own_req_s || others_s));
   assign release_ptr_s = preempt_s ? rr_ptr_q : pick_ptr_s;

   // Track the preempted owner until the urgent grant is released.
   always_comb begin
      resume_vld_d = resume_vld_q;
      resume_ptr_d = resume_ptr_q;
      if (preempt_s) begin
         resume_vld_d = 1'b1;
         resume_ptr_d = owner_q;
      end else if (release_s) begin
         resume_vld_d = 1'b0;
      end else begin
         resume_vld_d = resume_vld_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         resume_vld_q <= 1'b0;
         resume_ptr_q <= {IDX_W{1'b0}};
      end else begin
         resume_vld_q <= resume_vld_d;
         resume_ptr_q <= resume_ptr_d;
      end
   end
`else
   assign pick_ptr_s    = (state_q == OWN) ? owner_inc_s : rr_ptr_q;
   assign pick_vld_s    = rr_vld_s;
   assign pick_idx_s    = rr_idx_s;
   assign release_s     = expired_s && (!own_req_s || others_s);
   assign release_ptr_s = owner_inc_s;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_in    (req_in),
      .ptr_in    (pick_ptr_s),
      .valid_out (rr_vld_s),
      .idx_out   (rr_idx_s)
   );

   // Next-state and next-output computation for the grant FSM.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      active_d   = active_q;
      disp_d     = disp_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld_s) begin
               state_d    = OWN;
               gnt_d      = GNT_ONE << pick_idx_s;
               owner_d    = pick_idx_s;
               active_d   = 1'b1;
               disp_d     = words_s[pick_idx_s];
               hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         OWN: begin
            if (release_s) begin
               rr_ptr_d = release_ptr_s;
               if (pick_vld_s) begin
                  state_d    = OWN;
                  gnt_d      = GNT_ONE << pick_idx_s;
                  owner_d    = pick_idx_s;
                  active_d   = 1'b1;
                  disp_d     = words_s[pick_idx_s];
                  hold_cnt_d = {HOLD_W{1'b0}};
               end else begin
                  // Owner and data stay so the display does not blank.
                  state_d    = IDLE;
                  gnt_d      = {NUM_REQ{1'b0}};
                  active_d   = 1'b0;
                  hold_cnt_d = {HOLD_W{1'b0}};
               end
            end else begin
               hold_cnt_d = expired_s ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
               if (own_req_s) begin
                  disp_d = words_s[owner_q];
               end else begin
                  disp_d = disp_q;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            gnt_d      = {NUM_REQ{1'b0}};
            active_d   = 1'b0;
            hold_cnt_d = {HOLD_W{1'b0}};
         end
      endcase
   end

   // Grant FSM state and registered outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         gnt_q      <= {NUM_REQ{1'b0}};
         owner_q    <= {IDX_W{1'b0}};
         active_q   <= 1'b0;
         disp_q     <= disp_word_t'({DISP_W{1'b0}});
         rr_ptr_q   <= {IDX_W{1'b0}};
         hold_cnt_q <= {HOLD_W{1'b0}};
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         active_q   <= active_d;
         disp_q     <= disp_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign gnt_out         = gnt_q;
   assign owner_out       = owner_q;
   assign active_out      = active_q;
   assign channel_sel_out = disp_q.channel;
   assign lt_out          = disp_q.lt;
   assign ut_out          = disp_q.ut;

endmodule

// File: tb/tb_ssc_share_arbiter.sv
// Self-checking bench for ssc_share_arbiter (NUM_REQ=4, HOLD_CYCLES=8): vector table,
// directed multi-cycle sequences and randomized traffic against a reference model.
module tb_ssc_share_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int HOLD_CYCLES = 8;

   logic        clk_in   = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [3:0]  req_in   = '0;
   logic [95:0] val_in   = '0;
   logic [3:0]  gnt_out;
   logic [1:0]  owner_out;
   logic        active_out;
   logic [7:0]  channel_sel_out;
   logic [7:0]  lt_out;
   logic [7:0]  ut_out;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit          m_busy;
   int          m_owner;
   int          m_age;
   int          m_ptr;
   logic [23:0] m_disp;

   typedef struct {
      logic [3:0]  req;
      logic [95:0] val;
      logic [3:0]  gnt;
      logic [1:0]  own;
      logic        act;
      logic [23:0] disp;
   } vec_t;

   vec_t vecs[$];

   ssc_share_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .req_in          (req_in),
      .val_in          (val_in),
      .gnt_out         (gnt_out),
      .owner_out       (owner_out),
      .active_out      (active_out),
      .channel_sel_out (channel_sel_out),
      .lt_out          (lt_out),
      .ut_out          (ut_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                          input logic a, input logic [23:0] d);
      chk({tag, " gnt"},    32'(gnt_out),    32'(g));
      chk({tag, " owner"},  32'(owner_out),  32'(o));
      chk({tag, " active"}, 32'(active_out), 32'(a));
      chk({tag, " data"},   32'({channel_sel_out, lt_out, ut_out}), 32'(d));
   endtask

   function automatic logic [95:0] vw(input int i, input logic [23:0] w);
      logic [95:0] r;
      r = '0;
      r[24*i +: 24] = w;
      return r;
   endfunction

   function automatic void add_vec(input logic [3:0] req, input logic [95:0] val,
                                   input logic [3:0] gnt, input logic [1:0] own,
                                   input logic act, input logic [23:0] disp);
      vec_t v;
      v.req = req; v.val = val; v.gnt = gnt; v.own = own; v.act = act; v.disp = disp;
      vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0;
      req_in   = '0;
      val_in   = '0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int ptr);
      for (int off = 0; off < NUM_REQ; off++) begin
         if (r[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_owner = 0; m_age = 0; m_ptr = 0; m_disp = '0;
   endtask

   task automatic model_grant(input int k, input logic [95:0] v);
      m_busy  = 1'b1;
      m_owner = k;
      m_age   = 0;
      m_disp  = v[24*k +: 24];
   endtask

   // One clock edge of the specified behaviour, from the inputs seen at that edge.
   task automatic model_step(input logic [3:0] r, input logic [95:0] v);
      bit mine;
      bit others;
      if (!m_busy) begin
         if (r != 4'b0000) model_grant(rr_pick(r, m_ptr), v);
      end else begin
         mine   = r[m_owner];
         others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
         if (m_age >= HOLD_CYCLES - 1 && (!mine || others)) begin
            m_ptr = (m_owner + 1) % NUM_REQ;
            if (others) model_grant(rr_pick(r, m_ptr), v);
            else m_busy = 1'b0;
         end else begin
            m_age++;
            if (mine) m_disp = v[24*m_owner +: 24];
         end
      end
   endtask

   initial begin
      // Vector table, applied from a fresh reset; each row is one clock.
      add_vec(4'b0000, '0, 4'b0000, 2'd0, 1'b0, 24'h000000);
      add_vec(4'b0100, vw(2, 24'h112233), 4'b0100, 2'd2, 1'b1, 24'h112233);
      for (int i = 0; i < 12; i++)
         add_vec(4'b0100, vw(2, 24'h112233), 4'b0100, 2'd2, 1'b1, 24'h112233);
      add_vec(4'b0100, vw(2, 24'h0a0b0c), 4'b0100, 2'd2, 1'b1, 24'h0a0b0c);
      add_vec(4'b0110, vw(2, 24'h0a0b0c) | vw(1, 24'h010101), 4'b0010, 2'd1, 1'b1, 24'h010101);
      add_vec(4'b0110, vw(2, 24'h0a0b0c) | vw(1, 24'h020202), 4'b0010, 2'd1, 1'b1, 24'h020202);

      @(negedge clk_in);
      chk_all("reset", 4'b0000, 2'd0, 1'b0, 24'h000000);
      rst_n_in = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         req_in = vecs[i].req;
         val_in = vecs[i].val;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].own, vecs[i].act, vecs[i].disp);
      end

      // Contention from reset: 1 first, 3 after 8 cycles, 1 again after 8 more.
      do_reset();
      req_in = 4'b1010;
      val_in = vw(1, 24'h010203) | vw(3, 24'h0a0b0c);
      step();
      chk_all("cont g1", 4'b0010, 2'd1, 1'b1, 24'h010203);
      for (int j = 1; j < 8; j++) begin
         step();
         chk_all("cont hold1", 4'b0010, 2'd1, 1'b1, 24'h010203);
      end
      step();
      chk_all("cont g3", 4'b1000, 2'd3, 1'b1, 24'h0a0b0c);
      for (int j = 1; j < 8; j++) begin
         step();
         chk_all("cont hold3", 4'b1000, 2'd3, 1'b1, 24'h0a0b0c);
      end
      step();
      chk_all("cont g1 again", 4'b0010, 2'd1, 1'b1, 24'h010203);

      // Early drop: value frozen, grant kept until expiry, display retained after.
      do_reset();
      req_in = 4'b1000;
      val_in = vw(3, 24'h778899);
      step();
      chk_all("drop g3", 4'b1000, 2'd3, 1'b1, 24'h778899);
      val_in = vw(3, 24'h445566);
      step();
      chk_all("drop upd", 4'b1000, 2'd3, 1'b1, 24'h445566);
      step();
      chk_all("drop upd2", 4'b1000, 2'd3, 1'b1, 24'h445566);
      req_in = 4'b0000;
      val_in = vw(3, 24'hdeadbe);
      for (int j = 3; j < 8; j++) begin
         step();
         chk_all("drop frozen", 4'b1000, 2'd3, 1'b1, 24'h445566);
      end
      step();
      chk_all("drop released", 4'b0000, 2'd3, 1'b0, 24'h445566);
      step();
      chk_all("drop idle", 4'b0000, 2'd3, 1'b0, 24'h445566);

      // Reset mid-grant clears outputs before the next clock.
      do_reset();
      req_in = 4'b0001;
      val_in = vw(0, 24'habcdef);
      step();
      chk_all("rst g0", 4'b0001, 2'd0, 1'b1, 24'habcdef);
      for (int j = 0; j < 5; j++) step();
      rst_n_in = 1'b0;
      #1;
      chk_all("rst async", 4'b0000, 2'd0, 1'b0, 24'h000000);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      step();
      chk_all("rst regrant", 4'b0001, 2'd0, 1'b1, 24'habcdef);

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) req_in = 4'($urandom_range(0, 15));
         val_in = {$urandom, $urandom, $urandom};
         step();
         model_step(req_in, val_in);
         chk_all("rand", m_busy ? (4'b0001 << m_owner) : 4'b0000, 2'(m_owner), m_busy, m_disp);
         chk("rand onehot", 32'($onehot0(gnt_out)), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
